// File: rtl/prefetch_queue_if.sv
// Prefetch queue bundle: redirect request, instruction-memory request/response
// and decode-side instruction handshake. The master modport is the prefetch
// queue's view; the slave modport is the surrounding core/memory view.
// The misalign_err signal exists only when PREFETCH_MISALIGN_CHK_EN is defined.
interface prefetch_queue_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            inst_valid;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;
`ifdef PREFETCH_MISALIGN_CHK_EN
  logic            misalign_err;
`endif

  modport master (
`ifdef PREFETCH_MISALIGN_CHK_EN
    output misalign_err,
`endif
    input  redirect_valid,
    input  redirect_pc,
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
`ifdef PREFETCH_MISALIGN_CHK_EN
    input  misalign_err,
`endif
    output redirect_valid,
    output redirect_pc,
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue.
// Issues sequential fetch requests while queue occupancy plus in-flight
// requests leave room, tracks the PC of every in-flight request in an
// in-order PC FIFO, buffers returned words with their PCs, and presents the
// head to decode through registered outputs. A redirect flushes the queue,
// retargets fetch and marks every in-flight response for discard.
// Optional feature macro: PREFETCH_MISALIGN_CHK_EN -- adds misalign_err and
// turns a redirect to a non-word-aligned PC into a flush-only event. Without
// it the low two bits of the redirect target are forced to zero.
module prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
  input  logic             clk,
  input  logic             reset_n,
  prefetch_queue_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CW  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'h0000_0004);
  localparam logic [XLEN-1:0] PC_ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  // Fetch side state
  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] fetch_pc_next_s;
  logic            started_r;

  // In-flight bookkeeping
  logic [CW-1:0]   out_cnt_r;
  logic [CW-1:0]   out_cnt_next_s;
  logic [CW-1:0]   disc_cnt_r;
  logic [CW-1:0]   disc_cnt_next_s;
  logic [XLEN-1:0] pcf_mem_r [DEPTH];
  logic [AW-1:0]   pcf_wr_r;
  logic [AW-1:0]   pcf_rd_r;

  // Instruction queue
  logic [31:0]     q_data_r [DEPTH];
  logic [XLEN-1:0] q_pc_r   [DEPTH];
  logic [AW-1:0]   q_head_r;
  logic [AW-1:0]   q_tail_r;
  logic [AW-1:0]   q_head_next_s;
  logic [CW-1:0]   q_cnt_r;
  logic [CW-1:0]   q_cnt_after_pop_s;
  logic [CW-1:0]   q_cnt_next_s;

  // Registered decode-side outputs
  logic            inst_valid_r;
  logic [31:0]     inst_data_r;
  logic [XLEN-1:0] inst_pc_r;
  logic            inst_valid_next_s;
  logic [31:0]     inst_data_next_s;
  logic [XLEN-1:0] inst_pc_next_s;

  // Per-cycle events
  logic [CW:0]     credit_sum_s;
  logic            credit_ok_s;
  logic            req_s;
  logic            grant_s;
  logic            resp_s;
  logic            drop_s;
  logic            push_s;
  logic            pop_s;
  logic            flush_s;
  logic            move_pc_s;
  logic [XLEN-1:0] redirect_target_s;
  logic [XLEN-1:0] resp_pc_s;

`ifdef PREFETCH_MISALIGN_CHK_EN
  logic            misalign_s;
  logic            misalign_err_r;

  // Redirect decode: a misaligned target flushes but leaves fetch PC alone.
  always_comb begin
    flush_s           = bus.redirect_valid;
    misalign_s        = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    move_pc_s         = bus.redirect_valid && !misalign_s;
    redirect_target_s = bus.redirect_pc;
  end
`else
  // Redirect decode: target is always forced onto a word boundary.
  always_comb begin
    flush_s           = bus.redirect_valid;
    move_pc_s         = bus.redirect_valid;
    redirect_target_s = bus.redirect_pc & PC_ALIGN_MASK;
  end
`endif

  // Request/response events; a redirect blocks requests and pops in its cycle.
  always_comb begin
    credit_sum_s = {1'b0, q_cnt_r} + {1'b0, out_cnt_r};
    credit_ok_s  = (credit_sum_s < DEPTH_EXT);
    req_s        = started_r && credit_ok_s && !flush_s;
    grant_s      = req_s && bus.imem_gnt;
    resp_s       = bus.imem_rvalid && (out_cnt_r != CNT_ZERO);
    drop_s       = resp_s && ((disc_cnt_r != CNT_ZERO) || flush_s);
    pop_s        = inst_valid_r && bus.inst_ready && !flush_s;
    push_s       = resp_s && !drop_s && ((q_cnt_r != DEPTH_CW) || pop_s);
    resp_pc_s    = pcf_mem_r[pcf_rd_r];
  end

  // Next fetch PC: redirect first, then advance on grant.
  always_comb begin
    fetch_pc_next_s = fetch_pc_r;
    if (move_pc_s) begin
      fetch_pc_next_s = redirect_target_s;
    end else if (grant_s) begin
      fetch_pc_next_s = fetch_pc_r + PC_STEP;
    end else begin
      fetch_pc_next_s = fetch_pc_r;
    end
  end

  // Outstanding and discard counters; a redirect marks all in-flight for discard.
  always_comb begin
    out_cnt_next_s  = out_cnt_r;
    disc_cnt_next_s = disc_cnt_r;
    if (grant_s && !resp_s) begin
      out_cnt_next_s = out_cnt_r + CNT_ONE;
    end else if (!grant_s && resp_s) begin
      out_cnt_next_s = out_cnt_r - CNT_ONE;
    end else begin
      out_cnt_next_s = out_cnt_r;
    end
    if (flush_s) begin
      disc_cnt_next_s = out_cnt_next_s;
    end else if (resp_s && (disc_cnt_r != CNT_ZERO)) begin
      disc_cnt_next_s = disc_cnt_r - CNT_ONE;
    end else begin
      disc_cnt_next_s = disc_cnt_r;
    end
  end

  // Queue occupancy and head movement.
  always_comb begin
    q_cnt_after_pop_s = pop_s ? (q_cnt_r - CNT_ONE) : q_cnt_r;
    q_head_next_s     = q_head_r;
    q_cnt_next_s      = q_cnt_r;
    if (flush_s) begin
      q_head_next_s = q_tail_r;
      q_cnt_next_s  = CNT_ZERO;
    end else begin
      q_head_next_s = pop_s ? (q_head_r + PTR_ONE) : q_head_r;
      q_cnt_next_s  = push_s ? (q_cnt_after_pop_s + CNT_ONE) : q_cnt_after_pop_s;
    end
  end

  // Next head view; a word written into an otherwise empty queue becomes the head.
  always_comb begin
    inst_valid_next_s = 1'b0;
    inst_data_next_s  = 32'h0000_0000;
    inst_pc_next_s    = PC_ZERO;
    if (flush_s) begin
      inst_valid_next_s = 1'b0;
    end else if (q_cnt_after_pop_s != CNT_ZERO) begin
      inst_valid_next_s = 1'b1;
      inst_data_next_s  = q_data_r[q_head_next_s];
      inst_pc_next_s    = q_pc_r[q_head_next_s];
    end else if (push_s) begin
      inst_valid_next_s = 1'b1;
      inst_data_next_s  = bus.imem_rdata;
      inst_pc_next_s    = resp_pc_s;
    end else begin
      inst_valid_next_s = 1'b0;
    end
  end

  // Fetch PC register and the one-cycle post-reset request hold-off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_r <= RESET_PC;
      started_r  <= 1'b0;
    end else begin
      fetch_pc_r <= fetch_pc_next_s;
      started_r  <= 1'b1;
    end
  end

  // Outstanding/discard counters and PC FIFO pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt_r  <= CNT_ZERO;
      disc_cnt_r <= CNT_ZERO;
      pcf_wr_r   <= {AW{1'b0}};
      pcf_rd_r   <= {AW{1'b0}};
    end else begin
      out_cnt_r  <= out_cnt_next_s;
      disc_cnt_r <= disc_cnt_next_s;
      if (grant_s) begin
        pcf_wr_r <= pcf_wr_r + PTR_ONE;
      end
      if (resp_s) begin
        pcf_rd_r <= pcf_rd_r + PTR_ONE;
      end
    end
  end

  // PC FIFO storage: remember the address of every granted request.
  always_ff @(posedge clk) begin
    if (grant_s) begin
      pcf_mem_r[pcf_wr_r] <= fetch_pc_r;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_head_r <= {AW{1'b0}};
      q_tail_r <= {AW{1'b0}};
      q_cnt_r  <= CNT_ZERO;
    end else begin
      q_head_r <= q_head_next_s;
      q_cnt_r  <= q_cnt_next_s;
      if (push_s) begin
        q_tail_r <= q_tail_r + PTR_ONE;
      end
    end
  end

  // Queue storage: write accepted responses at the tail with their PC.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_data_r[q_tail_r] <= bus.imem_rdata;
      q_pc_r[q_tail_r]   <= resp_pc_s;
    end
  end

  // Registered head outputs toward decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inst_valid_r <= 1'b0;
      inst_data_r  <= 32'h0000_0000;
      inst_pc_r    <= PC_ZERO;
    end else begin
      inst_valid_r <= inst_valid_next_s;
      inst_data_r  <= inst_data_next_s;
      inst_pc_r    <= inst_pc_next_s;
    end
  end

`ifdef PREFETCH_MISALIGN_CHK_EN
  // One-cycle error pulse following a misaligned redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_err_r <= 1'b0;
    end else begin
      misalign_err_r <= misalign_s;
    end
  end

  assign bus.misalign_err = misalign_err_r;
`endif

  assign bus.imem_req   = req_s;
  assign bus.imem_addr  = fetch_pc_r;
  assign bus.inst_valid = inst_valid_r;
  assign bus.inst_data  = inst_data_r;
  assign bus.inst_pc    = inst_pc_r;

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue. A transaction-level reference model
// (queues of in-flight fetches and buffered instructions) predicts request,
// address and head outputs every cycle; directed steps cover reset, streaming,
// back-pressure, stalled grants, redirects and near-full push+pop, followed
// by a randomized phase.
module tb_prefetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          disc;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic reset_n;

  prefetch_queue_if #(.XLEN(32)) bus ();

  prefetch_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          vectors    = 0;
  int          miscompares = 0;
  int          cyc        = 0;
  int          grant_cnt  = 0;
  int          lat_min    = 0;
  int          lat_max    = 0;
  logic [31:0] model_pc;
  bit          exp_mis    = 1'b0;
  pend_t       pend[$];
  ent_t        expq[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0000_0000;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0000_0000;
    bus.inst_ready     = 1'b0;
  endtask

  // mid=1: assert reset asynchronously between clock edges.
  task automatic do_reset(input bit mid);
    if (mid) #3;
    reset_n = 1'b0;
    drive_idle();
    #1;
    chk("rst_imem_req",   bus.imem_req,   1'b0);
    chk("rst_imem_addr",  bus.imem_addr,  RESET_PC);
    chk("rst_inst_valid", bus.inst_valid, 1'b0);
    chk("rst_inst_data",  bus.inst_data,  32'h0000_0000);
    chk("rst_inst_pc",    bus.inst_pc,    32'h0000_0000);
`ifdef PREFETCH_MISALIGN_CHK_EN
    chk("rst_misalign",   bus.misalign_err, 1'b0);
`endif
    pend.delete();
    expq.delete();
    model_pc = RESET_PC;
    exp_mis  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("req_after_release", bus.imem_req, 1'b0);
  endtask

  // One clock cycle: check registered outputs, drive inputs, check request
  // outputs, then advance the reference model across the rising edge.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input int gnt_pct, input int rdy_pct);
    bit    exp_req;
    bit    grant;
    bit    resp;
    bit    rdy;
    pend_t r;
    ent_t  e;
    @(negedge clk);
    chk("inst_valid", bus.inst_valid, expq.size() != 0);
    if (expq.size() != 0) begin
      chk("inst_pc",   bus.inst_pc,   expq[0].pc);
      chk("inst_data", bus.inst_data, expq[0].data);
    end
`ifdef PREFETCH_MISALIGN_CHK_EN
    chk("misalign_err", bus.misalign_err, exp_mis);
`endif
    rdy = ($urandom_range(99, 0) < rdy_pct);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.inst_ready     = rdy;
    bus.imem_gnt       = ($urandom_range(99, 0) < gnt_pct);
    resp = (pend.size() != 0) && (pend[0].due <= cyc);
    bus.imem_rvalid = resp;
    bus.imem_rdata  = resp ? mem_word(pend[0].addr) : $urandom;
    #1;
    exp_req = !redir && ((expq.size() + pend.size()) < DEPTH);
    chk("imem_req", bus.imem_req, exp_req);
    if (exp_req) chk("imem_addr", bus.imem_addr, model_pc);
    grant = exp_req && bus.imem_gnt;
    @(posedge clk);
    if (resp) r = pend.pop_front();
    if (redir) begin
      foreach (pend[i]) pend[i].disc = 1'b1;
      expq.delete();
`ifdef PREFETCH_MISALIGN_CHK_EN
      exp_mis = (rpc[1:0] != 2'b00);
      if (!exp_mis) model_pc = rpc;
`else
      exp_mis  = 1'b0;
      model_pc = rpc & 32'hFFFF_FFFC;
`endif
    end else begin
      exp_mis = 1'b0;
      if (rdy && expq.size() != 0) e = expq.pop_front();
      if (resp && !r.disc) begin
        e.pc   = r.addr;
        e.data = mem_word(r.addr);
        expq.push_back(e);
      end
      if (grant) begin
        r.addr = model_pc;
        r.due  = cyc + 1 + int'($urandom_range(lat_max, lat_min));
        r.disc = 1'b0;
        pend.push_back(r);
        model_pc  = model_pc + 32'h0000_0004;
        grant_cnt++;
      end
    end
    cyc++;
  endtask

  initial begin
    int  g0;
    int  n;
    bit  hit;
    int  rdy_pct;
    drive_idle();

    // Reset values, then full-rate streaming: PCs 0x0, 0x4, 0x8 back to back.
    lat_min = 0; lat_max = 0;
    do_reset(1'b0);
    cycle(1'b0, 32'h0, 100, 100);
    cycle(1'b0, 32'h0, 100, 100);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stream_valid", bus.inst_valid, 1'b1);
      chk("stream_pc",    bus.inst_pc,    32'(k * 4));
      chk("stream_data",  bus.inst_data,  mem_word(32'(k * 4)));
      cycle(1'b0, 32'h0, 100, 100);
    end
    for (int k = 0; k < 8; k++) cycle(1'b0, 32'h0, 100, 100);

    // Decode stalled: exactly DEPTH grants, then request stays low.
    do_reset(1'b0);
    g0 = grant_cnt;
    for (int k = 0; k < 12; k++) cycle(1'b0, 32'h0, 100, 0);
    chk("stall_grants", 32'(grant_cnt - g0), 32'd4);
    #1;
    chk("stall_req",    bus.imem_req,   1'b0);
    chk("stall_pc",     bus.inst_pc,    32'h0000_0000);
    chk("stall_valid",  bus.inst_valid, 1'b1);

    // Grant withheld for three cycles: address holds at 0x0.
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 0, 100);
    #1;
    chk("nogrant_addr", bus.imem_addr, 32'h0000_0000);
    for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 100, 100);

    // Redirect to 0x100 with two requests in flight.
    lat_min = 2; lat_max = 2;
    do_reset(1'b0);
    cycle(1'b0, 32'h0, 100, 100);
    cycle(1'b0, 32'h0, 100, 100);
    chk("redir_inflight", 32'(pend.size()), 32'd2);
    cycle(1'b1, 32'h0000_0100, 100, 100);
    n = 0;
    #1;
    while (!bus.inst_valid && n < 20) begin
      cycle(1'b0, 32'h0, 100, 100);
      n++;
      #1;
    end
    chk("redir_wait_bounded", n < 20, 1'b1);
    chk("redir_first_pc", bus.inst_pc, 32'h0000_0100);
    for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 100, 100);

    // Near-full queue: pop and response in the same cycle.
    do_reset(1'b0);
    hit = 1'b0;
    n = 0;
    while (!hit && n < 30) begin
      hit = (expq.size() == 3) && (pend.size() != 0) && (pend[0].due <= cyc);
      rdy_pct = hit ? 100 : 0;
      cycle(1'b0, 32'h0, 100, rdy_pct);
      n++;
    end
    chk("pushpop_reached", hit, 1'b1);
    chk("pushpop_occupancy", 32'(expq.size()), 32'd3);
    #1;
    chk("pushpop_head", bus.inst_pc, 32'h0000_0004);
    for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 100, 0);

`ifdef PREFETCH_MISALIGN_CHK_EN
    // Misaligned redirect: flush only, fetch PC unchanged, one-cycle pulse.
    lat_min = 0; lat_max = 1;
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 32'h0, 100, 50);
    cycle(1'b1, 32'h0000_0102, 100, 100);
    cycle(1'b0, 32'h0, 100, 100);
    cycle(1'b0, 32'h0, 100, 100);
    for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 100, 100);
`endif

    // Reset in the middle of traffic abandons in-flight requests.
    lat_min = 0; lat_max = 3;
    for (int k = 0; k < 7; k++) cycle(1'b0, 32'h0, 100, 30);
    do_reset(1'b1);

    // Randomized traffic with occasional redirects and resets.
    for (int k = 0; k < 1500; k++) begin
      if (k % 500 == 499) begin
        do_reset(1'b1);
      end else begin
        cycle(($urandom_range(99, 0) < 3), $urandom_range(32'h3FF, 0), 70, 60);
      end
    end
    for (int k = 0; k < 10; k++) cycle(1'b0, 32'h0, 100, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
